// File: rtl/mult_div_unit_pkg.sv
// Shared types and sizing for the multiply/divide unit.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } stateT;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } opT;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One iteration of radix-2 Booth multiply or restoring divide.
module md_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  opT               op,
    input  logic [WIDTH:0]   pHi,
    input  logic [WIDTH-1:0] pLo,
    input  logic             qm1,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   nextPHi,
    output logic [WIDTH-1:0] nextPLo,
    output logic             nextQm1
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        sum     = pHi;
        shifted = {pHi[WIDTH-1:0], pLo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        fits    = (shifted >= {1'b0, operand});
        nextPHi = pHi;
        nextPLo = pLo;
        nextQm1 = qm1;
        if (op == OP_MULT) begin
            // Multiplicand is sign-extended so the WIDTH+1 accumulator keeps its sign
            case ({pLo[0], qm1})
                2'b01:   sum = pHi + {operand[WIDTH-1], operand};
                2'b10:   sum = pHi - {operand[WIDTH-1], operand};
                default: sum = pHi;
            endcase
            nextPHi = {sum[WIDTH], sum[WIDTH:1]};
            nextPLo = {sum[0], pLo[WIDTH-1:1]};
            nextQm1 = pLo[0];
        end else begin
            // pHi holds the partial remainder, pLo the dividend/quotient shift register
            nextPHi = fits ? diff : shifted;
            nextPLo = {pLo[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit feeding the HI/LO registers.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    stateT            state, nextState;
    opT               opReg;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   pHi;
    logic [WIDTH-1:0] pLo;
    logic             qm1;
    logic [CNT_W-1:0] count;
    logic             signQ, signR;

    logic [WIDTH:0]   stepPHi;
    logic [WIDTH-1:0] stepPLo;
    logic             stepQm1;
    logic [WIDTH-1:0] absA, absB;
    logic             accept, isDiv;

    md_step #(.WIDTH(WIDTH)) uStep (
        .op      (opReg),
        .pHi     (pHi),
        .pLo     (pLo),
        .qm1     (qm1),
        .operand (operand),
        .nextPHi (stepPHi),
        .nextPLo (stepPLo),
        .nextQm1 (stepQm1)
    );

    always_comb begin
        absA   = a_in[WIDTH-1] ? -a_in : a_in;
        absB   = b_in[WIDTH-1] ? -b_in : b_in;
        isDiv  = (opT'(op) == OP_DIV);
        // The done cycle still counts as busy, so a start there waits one more edge
        accept = (state == IDLE) && start && !done;
        busy   = (state != IDLE) || done;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = (isDiv && b_in == '0) ? DZ : RUN;
            RUN:  if (count == CNT_W'(1)) nextState = FIX;
            FIX:  nextState = IDLE;
            DZ:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            opReg    <= OP_MULT;
            operand  <= '0;
            pHi      <= '0;
            pLo      <= '0;
            qm1      <= 1'b0;
            count    <= '0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= nextState;
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg <= opT'(op);
                        count <= CNT_W'(WIDTH);
                        pHi   <= '0;
                        qm1   <= 1'b0;
                        signQ <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        signR <= a_in[WIDTH-1];
                        if (isDiv) begin
                            operand <= absB;
                            pLo     <= absA;
                        end else begin
                            operand <= a_in;
                            pLo     <= b_in;
                        end
                    end
                end
                RUN: begin
                    pHi   <= stepPHi;
                    pLo   <= stepPLo;
                    qm1   <= stepQm1;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (opReg == OP_MULT) begin
                        hi_out <= pHi[WIDTH-1:0];
                        lo_out <= pLo;
                    end else begin
                        lo_out <= signQ ? -pLo : pLo;
                        hi_out <= signR ? -pHi[WIDTH-1:0] : pHi[WIDTH-1:0];
                    end
                end
                DZ: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
